// File: rtl/seq_div.sv
// seq_div: 8-bit unsigned restoring divider, one quotient bit per clock.
// A single 16-bit accumulator holds partial remainder (upper byte) and
// dividend/quotient bits (lower byte); quotient bits shift in from the right.
module seq_div (
   input  logic       clk_i,
   input  logic       reset_i,   // synchronous, active-low
   input  logic       wrt_i,
   input  logic [7:0] dvd_i,
   input  logic [7:0] dvs_i,
   output logic [7:0] quot_o,
   output logic [7:0] rem_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       dbz_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  dvs_q, dvs_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dbz_q, dbz_d;

   // Trial subtract on the 9-bit shifted partial remainder; one extra bit
   // carries the borrow. The shifted remainder can reach 2*D-1, so an
   // 8-bit compare would lose the top bit.
   logic [9:0]  trial;
   logic        borrow;

   assign trial  = {1'b0, acc_q[15:7]} - {2'b00, dvs_q};
   assign borrow = trial[9];

   // Next-state: load on accepted strobe, iterate in RUN, hold otherwise
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (wrt_i) begin
               acc_d   = {8'h00, dvd_i};
               dvs_d   = dvs_i;
               cnt_d   = 4'd0;
               dbz_d   = (dvs_i == 8'h00);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Divisor 0 takes this same path: every trial succeeds, giving
            // quotient FF and the dividend as remainder.
            if (!borrow) acc_d = {trial[7:0], acc_q[6:0], 1'b1};
            else         acc_d = {acc_q[14:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset overrides everything including a load strobe
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         acc_q   <= 16'h0000;
         dvs_q   <= 8'h00;
         cnt_q   <= 4'd0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quot_o = acc_q[7:0];
   assign rem_o  = acc_q[15:8];
   assign busy_o = (state_q == S_RUN);
   assign done_o = (state_q == S_DONE);
   assign dbz_o  = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: reset, basic and edge divisions, divide by
// zero, ignored strobe during RUN, mid-run reset and back-to-back operation.
module tb_seq_div;

   logic       clk = 1'b0;
   logic       reset, wrt;
   logic [7:0] dvd, dvs;
   logic [7:0] quot, rem;
   logic       busy, done, dbz;

   int n_cmp = 0;
   int n_err = 0;

   seq_div dut (
      .clk_i(clk), .reset_i(reset), .wrt_i(wrt), .dvd_i(dvd), .dvs_i(dvs),
      .quot_o(quot), .rem_o(rem), .busy_o(busy), .done_o(done), .dbz_o(dbz)
   );

   always #5 clk = ~clk;

   // Advance one edge; sample and drive 1ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; wrt = 1'b1; dvd = 8'd200; dvs = 8'd7;
      tick(); tick();
      n_cmp++; if ({quot, rem} !== 16'h0000) begin n_err++; $display("FAIL reset_qr got %h/%h want 00/00", quot, rem); end
      n_cmp++; if ({busy, done, dbz} !== 3'b000) begin n_err++; $display("FAIL reset_flags got b%b d%b z%b want 000", busy, done, dbz); end
      reset = 1'b1; wrt = 1'b0;
      tick();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_idle got b%b d%b want 00", busy, done); end
   endtask

   task automatic test_basic();
      int nbusy;
      dvd = 8'd200; dvs = 8'd7; wrt = 1'b1;
      tick();
      wrt = 1'b0; dvd = 8'd1; dvs = 8'd1;   // must not be re-sampled
      nbusy = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy === 1'b1 && done === 1'b0) nbusy++;
         tick();
      end
      n_cmp++; if (nbusy !== 8) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 8", nbusy); end
      n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL basic_done got b%b d%b want 01", busy, done); end
      n_cmp++; if (quot !== 8'd28 || rem !== 8'd4 || dbz !== 1'b0) begin n_err++; $display("FAIL basic_result got %0d r%0d z%b want 28 r4 z0", quot, rem, dbz); end
      tick(); tick(); tick();
      n_cmp++; if (done !== 1'b1 || quot !== 8'd28 || rem !== 8'd4) begin n_err++; $display("FAIL basic_hold got d%b %0d r%0d want d1 28 r4", done, quot, rem); end
   endtask

   task automatic test_edges();
      logic [7:0] tdvd [4] = '{8'd255, 8'd255, 8'd5, 8'd254};
      logic [7:0] tdvs [4] = '{8'd1,   8'd255, 8'd9, 8'd128};
      logic [7:0] tq   [4] = '{8'd255, 8'd1,   8'd0, 8'd1};
      logic [7:0] tr   [4] = '{8'd0,   8'd0,   8'd5, 8'd126};
      for (int k = 0; k < 4; k++) begin
         dvd = tdvd[k]; dvs = tdvs[k]; wrt = 1'b1;
         tick();
         wrt = 1'b0;
         for (int i = 0; i < 8; i++) tick();
         n_cmp++; if (done !== 1'b1 || quot !== tq[k] || rem !== tr[k] || dbz !== 1'b0) begin n_err++; $display("FAIL edge_%0d_%0d got d%b %0d r%0d z%b want d1 %0d r%0d z0", tdvd[k], tdvs[k], done, quot, rem, dbz, tq[k], tr[k]); end
      end
   endtask

   task automatic test_dbz();
      dvd = 8'd77; dvs = 8'd0; wrt = 1'b1;
      tick();
      wrt = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (done !== 1'b1 || quot !== 8'hFF || rem !== 8'd77 || dbz !== 1'b1) begin n_err++; $display("FAIL dbz_77_0 got d%b %h r%0d z%b want d1 ff r77 z1", done, quot, rem, dbz); end
      dvd = 8'd10; dvs = 8'd3; wrt = 1'b1;
      tick();
      wrt = 1'b0;
      n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL dbz_reload got b%b d%b want 10", busy, done); end
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (done !== 1'b1 || quot !== 8'd3 || rem !== 8'd1 || dbz !== 1'b0) begin n_err++; $display("FAIL dbz_after got d%b %0d r%0d z%b want d1 3 r1 z0", done, quot, rem, dbz); end
   endtask

   task automatic test_wrt_ignored();
      dvd = 8'd100; dvs = 8'd3; wrt = 1'b1;
      tick();
      wrt = 1'b0;
      tick(); tick(); tick();
      dvd = 8'd9; dvs = 8'd9; wrt = 1'b1;
      tick();
      wrt = 1'b0;
      tick(); tick(); tick();
      n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL ign_not_early got b%b d%b want 10", busy, done); end
      tick();
      n_cmp++; if (done !== 1'b1 || quot !== 8'd33 || rem !== 8'd1) begin n_err++; $display("FAIL ign_result got d%b %0d r%0d want d1 33 r1", done, quot, rem); end
   endtask

   task automatic test_reset_mid();
      dvd = 8'd150; dvs = 8'd10; wrt = 1'b1;
      tick();
      wrt = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_cmp++; if ({quot, rem} !== 16'h0000 || {busy, done, dbz} !== 3'b000) begin n_err++; $display("FAIL rstmid_clear got %h/%h b%b d%b z%b want 00/00 000", quot, rem, busy, done, dbz); end
      // reset together with strobe: no load
      reset = 1'b0; wrt = 1'b1;
      tick();
      reset = 1'b1; wrt = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_vs_wrt got b%b want 0", busy); end
      dvd = 8'd150; dvs = 8'd10; wrt = 1'b1;
      tick();
      wrt = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (done !== 1'b1 || quot !== 8'd15 || rem !== 8'd0) begin n_err++; $display("FAIL rstmid_rerun got d%b %0d r%0d want d1 15 r0", done, quot, rem); end
   endtask

   task automatic test_back_to_back();
      int ndone;
      int nboth;
      dvd = 8'd50; dvs = 8'd7; wrt = 1'b1;
      tick();
      dvd = 8'd60; dvs = 8'd8;   // taken at the second acceptance edge
      ndone = 0; nboth = 0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (busy === 1'b1 && done === 1'b1) nboth++;
         if (done === 1'b1) ndone++;
         if (k == 8) begin
            n_cmp++; if (done !== 1'b1 || quot !== 8'd7 || rem !== 8'd1) begin n_err++; $display("FAIL b2b_first got d%b %0d r%0d want d1 7 r1", done, quot, rem); end
         end
         if (k == 9) begin
            n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL b2b_done_pulse got b%b d%b want 10", busy, done); end
         end
         if (k == 17) begin
            n_cmp++; if (done !== 1'b1 || quot !== 8'd7 || rem !== 8'd4) begin n_err++; $display("FAIL b2b_second got d%b %0d r%0d want d1 7 r4", done, quot, rem); end
         end
      end
      wrt = 1'b0;
      n_cmp++; if (ndone !== 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
      n_cmp++; if (nboth !== 0) begin n_err++; $display("FAIL b2b_busy_and_done got %0d want 0", nboth); end
   endtask

   initial begin
      reset = 1'b0; wrt = 1'b0; dvd = 8'd0; dvs = 8'd0;
      test_reset();
      test_basic();
      test_edges();
      test_dbz();
      test_wrt_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
